// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_e;

  // Width of the bit down-counter for a given word width (always at least 1 bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: valid/ready word load, one bit out per shift_en strobe,
// back-to-back frames without an idle gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             out_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (cnt_q == '0);

  // Ready either when idle or when the final bit of the current frame is being consumed.
  assign in_ready = ~reset & ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & last_bit & shift_en));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = data_in;
          cnt_d   = CntLoad;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (!last_bit) begin
            shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q - 1'b1;
          end else if (accept) begin
            shreg_d = data_in;
            cnt_d   = CntLoad;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    serial_out = IDLE_LEVEL;
    out_valid  = 1'b0;
    frame_last = 1'b0;
    busy       = 1'b0;
    if (state_q == ST_SHIFT) begin
      serial_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      out_valid  = 1'b1;
      frame_last = last_bit;
      busy       = 1'b1;
    end
  end

endmodule
